// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//
// Shares one status LED between a high-priority and a low-priority requester.
// A granted request plays its pattern LSB first, one bit per TICK_DIV clocks,
// then holds idleLevel for GAP_TICKS tick periods before re-arbitrating.
//
// Optional build macro: LED_PATTERN_SEQUENCER_FAIR_EN
//   undefined : fixed priority, hi always wins a tie (lo may starve)
//   defined   : round-robin on ties, alternating after a hi grant
//
// Ports:
//   clock, resetN          clock and asynchronous active-low reset
//   hiValid/hiReady        high-priority handshake, hiPattern/hiLength data
//   loValid/loReady        low-priority handshake, loPattern/loLength data
//   *Length                number of bits to play minus 1
//   idleLevel              LED level while idle and during the gap
//   led                    registered LED drive
//   busy                   high while playing or in the gap
//   grantHi                source of the current/last pattern (1 = hi)
module led_pattern_sequencer #(
    parameter int TICK_DIV      = 1000000,
    parameter int GAP_TICKS     = 4,
    parameter int PATTERN_WIDTH = 16,
    parameter int LEN_WIDTH     = 4
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     hiValid,
    output logic                     hiReady,
    input  logic [PATTERN_WIDTH-1:0] hiPattern,
    input  logic [LEN_WIDTH-1:0]     hiLength,
    input  logic                     loValid,
    output logic                     loReady,
    input  logic [PATTERN_WIDTH-1:0] loPattern,
    input  logic [LEN_WIDTH-1:0]     loLength,
    input  logic                     idleLevel,
    output logic                     led,
    output logic                     busy,
    output logic                     grantHi
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]               state;
    logic [TICK_W-1:0]        tickCnt;
    logic [LEN_WIDTH-1:0]     bitIdx;
    logic [GAP_W-1:0]         gapCnt;
    logic [PATTERN_WIDTH-1:0] patternReg;
    logic [LEN_WIDTH-1:0]     lengthReg;

    logic                     hiFire;
    logic                     loFire;
    logic                     accept;
    logic                     tick;
    logic                     idleNext;
    logic                     hiReadyNext;
    logic                     loReadyNext;
    logic [LEN_WIDTH-1:0]     nextIdx;

`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
    logic                     lastWasHi;
`endif

    always_comb begin
        tick    = (tickCnt == TICK_LAST);
        nextIdx = bitIdx + LEN_WIDTH'(1);
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
        // Readies are registered and may lag valid by a cycle, so the fire
        // logic re-applies the tie-break to keep at most one transfer.
        hiFire = hiValid && hiReady && !(lastWasHi && loValid && loReady);
`else
        hiFire = hiValid && hiReady;
`endif
        loFire   = loValid && loReady && !hiFire;
        accept   = hiFire || loFire;
        // Next state is IDLE: either staying idle or leaving the last gap tick.
        idleNext = ((state == IDLE) && !accept) ||
                   ((state == GAP) && tick && (gapCnt == GAP_LAST));
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
        hiReadyNext = idleNext && !(lastWasHi && hiValid && loValid);
        loReadyNext = idleNext && (!hiValid || lastWasHi);
`else
        hiReadyNext = idleNext;
        loReadyNext = idleNext && !hiValid;
`endif
    end

    // Pattern data carries no reset; it is only observed after an accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            patternReg <= hiFire ? hiPattern : loPattern;
            lengthReg  <= hiFire ? hiLength : loLength;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            tickCnt   <= '0;
            bitIdx    <= '0;
            gapCnt    <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            grantHi   <= 1'b0;
            hiReady   <= 1'b0;
            loReady   <= 1'b0;
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
            lastWasHi <= 1'b0;
`endif
        end else begin
            hiReady <= hiReadyNext;
            loReady <= loReadyNext;
            case (state)
                IDLE: begin
                    led <= idleLevel;
                    if (accept) begin
                        state   <= PLAY;
                        busy    <= 1'b1;
                        grantHi <= hiFire;
                        tickCnt <= '0;
                        bitIdx  <= '0;
                        // Bit 0 goes out on the accept edge itself.
                        led     <= hiFire ? hiPattern[0] : loPattern[0];
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
                        lastWasHi <= hiFire;
`endif
                    end
                end
                PLAY: begin
                    if (tick) begin
                        tickCnt <= '0;
                        if (bitIdx == lengthReg) begin
                            state  <= GAP;
                            gapCnt <= '0;
                            led    <= idleLevel;
                        end else begin
                            bitIdx <= nextIdx;
                            led    <= patternReg[nextIdx];
                        end
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                GAP: begin
                    led <= idleLevel;
                    if (tick) begin
                        tickCnt <= '0;
                        if (gapCnt == GAP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gapCnt <= gapCnt + GAP_W'(1);
                        end
                    end else begin
                        tickCnt <= tickCnt + TICK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int TD = 4;
    localparam int GT = 2;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        hiValid = 1'b0;
    logic        loValid = 1'b0;
    logic        idleLevel = 1'b0;
    logic [15:0] hiPattern = '0;
    logic [15:0] loPattern = '0;
    logic [3:0]  hiLength = '0;
    logic [3:0]  loLength = '0;
    logic        hiReady, loReady, led, busy, grantHi;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(
        .TICK_DIV(TD), .GAP_TICKS(GT), .PATTERN_WIDTH(16), .LEN_WIDTH(4)
    ) dut (
        .clock(clock), .resetN(resetN),
        .hiValid(hiValid), .hiReady(hiReady), .hiPattern(hiPattern), .hiLength(hiLength),
        .loValid(loValid), .loReady(loReady), .loPattern(loPattern), .loLength(loLength),
        .idleLevel(idleLevel), .led(led), .busy(busy), .grantHi(grantHi)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        bit          isHi;
        logic [15:0] pat;
        logic [3:0]  len;
        bit          idle;
        int          expBusy;
        int          expOnes;
    } vec_t;

    vec_t vecs[6];

    // Waits (bounded) for busy to fall; returns number of busy negedges seen.
    task automatic waitIdle(input string tag, output int cnt);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) return;
            cnt++;
        end
        check({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic runOne(input vec_t v, input string tag);
        bit accepted;
        int busyCnt, ones, plen;
        logic expLed;
        accepted = 0;
        @(negedge clock);
        idleLevel = v.idle;
        if (v.isHi) begin
            hiPattern = v.pat; hiLength = v.len; hiValid = 1'b1;
        end else begin
            loPattern = v.pat; loLength = v.len; loValid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            if ((v.isHi ? hiReady : loReady) === 1'b1) begin
                @(posedge clock);
                #1;
                hiValid = 1'b0;
                loValid = 1'b0;
                accepted = 1;
                break;
            end
            @(negedge clock);
        end
        if (!accepted) begin
            hiValid = 1'b0;
            loValid = 1'b0;
            check({tag, "_accept"}, 0, 1);
            return;
        end
        busyCnt = 0;
        ones = 0;
        plen = (int'(v.len) + 1) * TD;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!busy) break;
            busyCnt++;
            if (led) ones++;
            expLed = (k < plen) ? v.pat[k / TD] : v.idle;
            check($sformatf("%s_led_c%0d", tag, k), led, expLed);
        end
        check({tag, "_busy_cycles"}, busyCnt, v.expBusy);
        check({tag, "_ones"}, ones, v.expOnes);
        check({tag, "_grantHi"}, grantHi, v.isHi);
        check({tag, "_hiReady_after"}, hiReady, 1);
        check({tag, "_loReady_after"}, loReady, 1);
        check({tag, "_led_idle_after"}, led, v.idle);
    endtask

    initial begin
        int cnt, loSeen, grants, bad;
        bit prevBusy;
        bit expG;
        bit accepted;

        vecs[0] = '{1'b0, 16'h0005, 4'd2,  1'b0, 20, 8};
        vecs[1] = '{1'b1, 16'h0001, 4'd0,  1'b0, 12, 4};
        vecs[2] = '{1'b1, 16'hFFFF, 4'd15, 1'b1, 72, 72};
        vecs[3] = '{1'b0, 16'h8000, 4'd15, 1'b0, 72, 4};
        vecs[4] = '{1'b1, 16'h00A5, 4'd7,  1'b0, 40, 16};
        vecs[5] = '{1'b0, 16'hFFFE, 4'd0,  1'b0, 12, 0};

        // Reset state, with both requesters already valid.
        hiPattern = 16'h0001; hiLength = 4'd0;
        loPattern = 16'h0005; loLength = 4'd2;
        hiValid = 1'b1; loValid = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_grantHi", grantHi, 0);
        check("rst_hiReady", hiReady, 0);
        check("rst_loReady", loReady, 0);
        resetN = 1'b1;
        @(negedge clock);
        check("tie_hiReady", hiReady, 1);
        check("tie_loReady", loReady, 0);
        @(negedge clock);
        check("tie_busy", busy, 1);
        check("tie_grantHi", grantHi, 1);
        check("tie_led", led, 1);
        check("tie_hiReady_drop", hiReady, 0);
        check("tie_loReady_busy", loReady, 0);
        hiValid = 1'b0;
        waitIdle("tie", cnt);
        check("tie_busy_cycles", cnt + 1, 12);
        check("tie_loReady_idle", loReady, 1);
        @(negedge clock);
        check("tie_lo_busy", busy, 1);
        check("tie_lo_grantHi", grantHi, 0);
        check("tie_lo_led", led, 1);

        // Both requesters held continuously across five grants.
        hiValid = 1'b1; hiPattern = 16'h0001; hiLength = 4'd0;
        loPattern = 16'h0002; loLength = 4'd0;
        prevBusy = 1'b1;
        grants = 0;
        loSeen = 0;
        for (int i = 0; i < 400 && grants < 5; i++) begin
            @(negedge clock);
            if (loReady) loSeen++;
            if (busy && !prevBusy) begin
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
                expG = (grants % 2) == 0;
`else
                expG = 1'b1;
`endif
                check($sformatf("contend_grant%0d", grants), grantHi, expG);
                grants++;
            end
            prevBusy = busy;
        end
        hiValid = 1'b0; loValid = 1'b0;
        check("contend_grant_count", grants, 5);
`ifdef LED_PATTERN_SEQUENCER_FAIR_EN
        check("contend_lo_ready_seen", (loSeen > 0) ? 1 : 0, 1);
`else
        check("contend_lo_starved", loSeen, 0);
`endif
        waitIdle("contend", cnt);

        // Table-driven single-requester patterns.
        for (int i = 0; i < 6; i++) runOne(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of bit 2 of a 5-bit pattern.
        @(negedge clock);
        idleLevel = 1'b0;
        loPattern = 16'h001F; loLength = 4'd4; loValid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            if (loReady === 1'b1) begin
                @(posedge clock);
                #1;
                loValid = 1'b0;
                accepted = 1;
                break;
            end
            @(negedge clock);
        end
        loValid = 1'b0;
        check("rmid_accept", accepted, 1);
        repeat (10) @(negedge clock);
        check("rmid_pre_led", led, 1);
        check("rmid_pre_busy", busy, 1);
        resetN = 1'b0;
        #1;
        check("rmid_led", led, 0);
        check("rmid_busy", busy, 0);
        check("rmid_hiReady", hiReady, 0);
        check("rmid_loReady", loReady, 0);
        check("rmid_grantHi", grantHi, 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        check("rmid_hiReady_back", hiReady, 1);
        check("rmid_loReady_back", loReady, 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (led !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rmid_no_resume", bad, 0);

        // loValid raised while busy, dropped again before the block idles.
        @(negedge clock);
        hiPattern = 16'h0003; hiLength = 4'd1; hiValid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            if (hiReady === 1'b1) begin
                @(posedge clock);
                #1;
                hiValid = 1'b0;
                accepted = 1;
                break;
            end
            @(negedge clock);
        end
        hiValid = 1'b0;
        check("lobusy_accept", accepted, 1);
        cnt = 0;
        loSeen = 0;
        loPattern = 16'h0001; loLength = 4'd0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (!busy) break;
            cnt++;
            if (k == 2) loValid = 1'b1;
            if (k == 14) loValid = 1'b0;
            if (loReady) loSeen++;
        end
        loValid = 1'b0;
        check("lobusy_busy_cycles", cnt, 16);
        check("lobusy_loReady_seen", loSeen, 0);
        check("lobusy_grantHi_hold", grantHi, 1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (busy !== 1'b0) bad++;
        end
        check("lobusy_no_pending", bad, 0);
        check("lobusy_loReady_idle", loReady, 1);
        check("lobusy_grantHi_idle", grantHi, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
